fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Write-side controller for the shared asynchronous FIFO memory. It arbitrates the single FIFO write port round-robin among NUM_REQ requesters using a valid/ready handshake. It owns the binary and Gray write pointers and the registered full flag. It sits in the wclk domain and drives the memory's wr_en, data_in, b_wptr and full inputs; g_wptr goes to the read-domain synchroniser.

Parameters:
PTR_WIDTH, 5, address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits
DATA_WIDTH, 32, word width
NUM_REQ, 4, number of write requesters (2..16)

Ports:
wclk  input  1  write-domain clock; all state on rising edge
wrst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice i belongs to requester i
req_ready  output  NUM_REQ  one-hot grant; word i accepted when req_valid[i] & req_ready[i]
g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised into wclk
wr_en  output  1  memory write strobe
data_in  output  DATA_WIDTH  data to memory (granted requester's slice)
b_wptr  output  PTR_WIDTH+1  binary write pointer to memory
g_wptr  output  PTR_WIDTH+1  registered Gray write pointer to read domain
full  output  1  registered full flag
grant_idx  output  $clog2(NUM_REQ)  index of the current grant; valid when wr_en=1

Behaviour:
- Reset (wrst=1 at a wclk edge): b_wptr=0, g_wptr=0, full=0, rr_last=NUM_REQ-1, so requester 0 has top priority next. While wrst=1, req_ready=0 and wr_en=0 combinationally.
- Grant is combinational in the same cycle. If full=0 and any req_valid is set, grant the first asserted requester searching from rr_last+1 upward, modulo NUM_REQ. req_ready is the one-hot grant, wr_en = |req_ready, and data_in and grant_idx are muxed from the winner.
- If full=1, then req_ready=0 and wr_en=0. Requesters hold req_valid and data; no data is dropped.
- On an accepted write: b_wptr <= b_wptr+1 (wraps 2**(PTR_WIDTH+1)-1 -> 0), g_wptr <= bin2gray(b_wptr+1), and rr_last <= grant_idx. With no write, all three hold.
- Full is computed one cycle ahead. full <= (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}), where g_wptr_next is the post-write Gray pointer. full deasserts the cycle after g_rptr_sync shows a read.
- Exactly one write per cycle maximum. Accepts are back-to-back at 1 word/cycle until full.
- A requester that drops req_valid while not granted loses nothing. rr_last is unaffected by cycles without grant.
- Single requester active: it is granted every cycle.
- Reset mid-burst: the current cycle's grant is suppressed and all state returns to reset values the next cycle. The read side must also be reset; this is a system requirement.

Optional Feature:
Macro FIFO_WR_ALMOST_FULL_EN.
- Defined: adds parameter AF_THRESH (default 2**PTR_WIDTH-4) and output almost_full (1 bit, reset 0). The registered occupancy_next = b_wptr_next - gray2bin(g_rptr_sync), modulo 2**(PTR_WIDTH+1). almost_full <= (occupancy_next >= AF_THRESH). Grant logic is unchanged.
- Undefined: no port, parameter or logic.

Decomposition:
- Package fifo_pkg holds:
  - typedef ptr_t (logic [PTR_WIDTH:0]), fixed via package parameter
  - functions bin2gray and gray2bin
  - constant DEPTH
- Sub-module rr_arbiter #(N) (inputs req, last, enable; outputs one-hot gnt, gnt_idx) is instantiated once.
- Pointer and full logic stays in the top level.

Test Plan:
- Reset, then req_valid=4'b0000 for 5 cycles -> wr_en=0, b_wptr=0, full=0, req_ready=0.
- req_valid=4'b1111 held for 8 cycles, empty FIFO -> grants 0,1,2,3,0,1,2,3; b_wptr=8; g_wptr=6'b001100.
- Requester 2 only, g_rptr_sync=0, 32 cycles -> 32 writes, full=1 after the 32nd write; cycle 33 req_ready=0, b_wptr=32.
- From the full state, set g_rptr_sync=bin2gray(1) -> full=0 next cycle, one more write, full=1 again, b_wptr=33.
- Wrap: drive the read pointer along so b_wptr passes 63 -> 0, and check g_wptr and full stay correct across the wrap.
- Assert wrst during a 4-requester burst -> same-cycle wr_en=0; next cycle pointers=0, full=0; the first grant after release goes to requester 0. With FIFO_WR_ALMOST_FULL_EN, AF_THRESH=28: almost_full=1 after the 28th write.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the asynchronous FIFO.
//                Provides the pointer type (one wrap bit above the address
//                bits), the FIFO depth, and the binary/Gray conversions used
//                by both clock domains.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Address bits of the FIFO memory. Every block that exchanges pointers
    // is elaborated with this width.
    parameter int FIFO_PTR_WIDTH = 5;

    // Number of words held by the memory.
    localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;

    // Pointer: address bits plus one wrap bit, which lets full and empty be
    // told apart when the address bits are equal.
    typedef logic [FIFO_PTR_WIDTH:0] ptr_t;

    // Binary to reflected Gray code.
    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary: each binary bit is the XOR of all
    // Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[FIFO_PTR_WIDTH] = gray[FIFO_PTR_WIDTH];
        for (int i = FIFO_PTR_WIDTH - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting one position above the last winner and
//                wrapping modulo N; the first asserted request wins.
//  Ports       : req      - request vector, one bit per requester
//                last     - index of the previous winner
//                enable   - when low no grant is issued
//                gnt      - one-hot grant
//                gnt_idx  - binary index of the granted requester
//                           (0 when nothing is granted)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Requester count in the width of the candidate sum so the modulo
    // reduction below compares like-sized operands.
    localparam logic [IW:0] c_n = (IW + 1)'(N);

    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Candidates are visited in priority order last+1, last+2, ..., last+N.
    // last never exceeds N-1, so a single conditional subtraction is enough
    // to wrap the sum back into range, and IW+1 bits hold it without
    // overflow.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, last} + (IW + 1)'(k);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            w_cand = w_sum[IW-1:0];
            if (enable && !w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = w_cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Write-side controller of the shared asynchronous FIFO.
//                Arbitrates the single memory write port round-robin among
//                NUM_REQ valid/ready requesters, owns the binary and Gray
//                write pointers, and produces a registered full flag that is
//                computed one cycle ahead from the post-write pointer.
//
//  Optional    : define FIFO_WR_ALMOST_FULL_EN to add parameter AF_THRESH and
//                the registered almost_full output. Grant behaviour is the
//                same with or without it.
//
//  Ports       : wclk, wrst   - write clock; synchronous active-high reset
//                req_valid    - per-requester write request
//                req_data     - packed data, slice i belongs to requester i
//                req_ready    - one-hot grant (word accepted on valid&ready)
//                g_rptr_sync  - Gray read pointer already in the wclk domain
//                wr_en        - memory write strobe
//                data_in      - granted requester's data to memory
//                b_wptr       - binary write pointer to memory
//                g_wptr       - registered Gray write pointer to read side
//                full         - registered full flag
//                almost_full  - registered occupancy >= AF_THRESH (optional)
//                grant_idx    - index of the winner, meaningful with wr_en
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    // Must match fifo_pkg::FIFO_PTR_WIDTH: pointers use the package type.
    parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH  = DEPTH - 4
`endif
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [PTR_WIDTH:0]            g_rptr_sync,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [PTR_WIDTH:0]            b_wptr,
    output logic [PTR_WIDTH:0]            g_wptr,
    output logic                          full,
`ifdef FIFO_WR_ALMOST_FULL_EN
    output logic                          almost_full,
`endif
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    ptr_t               r_b_wptr;
    ptr_t               r_g_wptr;
    logic               r_full;
    logic [c_idx_w-1:0] r_rr_last;

    // ------------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------------
    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_gnt;
    logic [c_idx_w-1:0] w_gnt_idx;
    logic               w_wr;

    // No grant while full (requesters simply hold their word) or while reset
    // is asserted (a burst interrupted by reset writes nothing that cycle).
    assign w_arb_en = ~wrst & ~r_full;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .last    (r_rr_last),
        .enable  (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_wr      = |w_gnt;
    assign req_ready = w_gnt;
    assign wr_en     = w_wr;
    assign grant_idx = w_gnt_idx;

    // With no grant the index is 0, so requester 0's slice shows up here;
    // the memory ignores it because wr_en is low.
    assign data_in   = req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------------
    // Next-pointer and full lookahead
    // ------------------------------------------------------------------------
    ptr_t w_b_wptr_next;
    ptr_t w_g_wptr_next;
    ptr_t w_full_pattern;

    // Binary increment wraps naturally at 2**(PTR_WIDTH+1).
    assign w_b_wptr_next = r_b_wptr + {{PTR_WIDTH{1'b0}}, w_wr};
    assign w_g_wptr_next = bin2gray(w_b_wptr_next);

    // In Gray code, "write pointer exactly one lap ahead of read pointer"
    // means the two MSBs differ and all lower bits match.
    assign w_full_pattern = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                              g_rptr_sync[PTR_WIDTH-2:0]};

    // full is evaluated every cycle against the freshly synchronised read
    // pointer, so it both asserts with the filling write and drops the
    // cycle after a read becomes visible.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_b_wptr  <= '0;
            r_g_wptr  <= '0;
            r_full    <= 1'b0;
            r_rr_last <= c_idx_w'(NUM_REQ - 1);
        end else begin
            r_b_wptr <= w_b_wptr_next;
            r_g_wptr <= w_g_wptr_next;
            r_full   <= (w_g_wptr_next == w_full_pattern);
            if (w_wr) begin
                r_rr_last <= w_gnt_idx;
            end
        end
    end

    assign b_wptr = r_b_wptr;
    assign g_wptr = r_g_wptr;
    assign full   = r_full;

`ifdef FIFO_WR_ALMOST_FULL_EN
    // ------------------------------------------------------------------------
    // Almost-full: occupancy after this cycle's write, modulo the pointer
    // range, compared against the threshold.
    // ------------------------------------------------------------------------
    localparam ptr_t c_af_thresh = ptr_t'(AF_THRESH);

    ptr_t w_occ_next;
    logic r_almost_full;

    assign w_occ_next = w_b_wptr_next - gray2bin(g_rptr_sync);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_occ_next >= c_af_thresh);
        end
    end

    assign almost_full = r_almost_full;
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Each cycle the
//                bench drives requests, predicts the winner with its own
//                round-robin model and queues the expected (index, data);
//                a negedge monitor pops and compares every DUT write.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int PW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             wclk = 1'b0;
    logic             wrst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [PW:0]      g_rptr_sync;
    logic             wr_en;
    logic [DW-1:0]    data_in;
    logic [PW:0]      b_wptr;
    logic [PW:0]      g_wptr;
    logic             full;
    logic [IW-1:0]    grant_idx;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic             almost_full;
`endif

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .PTR_WIDTH  (PW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .g_rptr_sync (g_rptr_sync),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
`ifdef FIFO_WR_ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .grant_idx   (grant_idx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    // Bench model state (register values seen during the current cycle).
    int m_b    = 0;
    int m_rr   = NR - 1;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;
    int m_seq  = 0;

    // Predictions for the cycle just driven.
    logic [NR-1:0] e_gnt;
    int            e_idx;
    int            cur_b;
    bit            cur_full;
    bit            cur_af;

    function automatic logic [PW:0] tb_gray(input int b);
        logic [PW:0] v;
        v = (PW + 1)'(b & 63);
        return v ^ (v >> 1);
    endfunction

    // Drive one cycle: inputs change 1 ns after the rising edge, the model
    // predicts the grant, and the task returns 3 ns after the edge so the
    // caller samples well before the next edge.
    task automatic drive_cycle(input bit rst, input logic [NR-1:0] valid,
                               input int rptr_bin);
        int nb;
        int occ;
        logic [31:0] d;
        @(posedge wclk);
        #1;
        m_seq++;
        wrst        = rst;
        req_valid   = valid;
        g_rptr_sync = tb_gray(rptr_bin);
        for (int i = 0; i < NR; i++) begin
            d = 32'((i << 28) + m_seq);
            req_data[i*DW +: DW] = d;
        end
        cur_b    = m_b;
        cur_full = m_full;
        cur_af   = m_af;
        e_gnt    = '0;
        e_idx    = -1;
        if (!rst && !m_full) begin
            for (int k = 1; k <= NR; k++) begin
                int j;
                j = (m_rr + k) % NR;
                if (e_idx < 0 && valid[j]) e_idx = j;
            end
        end
        if (e_idx >= 0) begin
            exp_t e;
            e_gnt[e_idx] = 1'b1;
            e.idx  = e_idx;
            e.data = 32'((e_idx << 28) + m_seq);
            sb_q.push_back(e);
        end
        if (rst) begin
            m_b = 0; m_rr = NR - 1; m_full = 1'b0; m_af = 1'b0;
        end else begin
            nb     = (m_b + ((e_idx >= 0) ? 1 : 0)) & 63;
            occ    = (nb - rptr_bin) & 63;
            m_full = (occ == 32);
            m_af   = (occ >= 28);
            if (e_idx >= 0) m_rr = e_idx;
            m_b = nb;
        end
        #2;
    endtask

    // Scoreboard monitor: every accepted write must match the oldest
    // prediction.
    always @(negedge wclk) begin
        if (wr_en === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got idx=%0d data=%h, required no write",
                         grant_idx, data_in);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (grant_idx !== 2'(e.idx) || data_in !== e.data)
                    $display("FAIL sb_write: got idx=%0d data=%h, required idx=%0d data=%h",
                             grant_idx, data_in, e.idx, e.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b1, 4'b1111, 0);
            n_checks++;
            if (wr_en !== 1'b0 || req_ready !== 4'b0000)
                $display("FAIL reset_grant_block: got wr_en=%b ready=%b, required 0/0000",
                         wr_en, req_ready);
            else n_pass++;
        end
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 4'b0000, 0);
            n_checks++;
            if (wr_en !== 1'b0 || b_wptr !== 6'd0 || full !== 1'b0 || req_ready !== 4'b0000)
                $display("FAIL reset_idle: got wr_en=%b b_wptr=%0d full=%b ready=%b, required 0/0/0/0000",
                         wr_en, b_wptr, full, req_ready);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b0, 4'b1111, 0);
            n_checks++;
            if (req_ready !== e_gnt || grant_idx !== 2'(c % 4) || wr_en !== 1'b1)
                $display("FAIL rr_grant: got ready=%b idx=%0d wr_en=%b, required ready=%b idx=%0d wr_en=1",
                         req_ready, grant_idx, wr_en, e_gnt, c % 4);
            else n_pass++;
        end
        drive_cycle(1'b0, 4'b0000, 0);
        n_checks++;
        if (b_wptr !== 6'd8 || g_wptr !== 6'b001100)
            $display("FAIL rr_pointers: got b=%0d g=%b, required b=8 g=001100", b_wptr, g_wptr);
        else n_pass++;
    endtask

    task automatic test_fill();
        drive_cycle(1'b1, 4'b0000, 0);
        for (int c = 0; c < 32; c++) begin
            drive_cycle(1'b0, 4'b0100, 0);
            n_checks++;
            if (req_ready !== 4'b0100 || b_wptr !== 6'(c) || full !== 1'b0)
                $display("FAIL fill_write: got ready=%b b=%0d full=%b, required ready=0100 b=%0d full=0",
                         req_ready, b_wptr, full, c);
            else n_pass++;
`ifdef FIFO_WR_ALMOST_FULL_EN
            n_checks++;
            if (almost_full !== cur_af)
                $display("FAIL fill_almost_full: got %b, required %b", almost_full, cur_af);
            else n_pass++;
`endif
        end
        drive_cycle(1'b0, 4'b0100, 0);
        n_checks++;
        if (full !== 1'b1 || req_ready !== 4'b0000 || wr_en !== 1'b0 || b_wptr !== 6'd32)
            $display("FAIL fill_full: got full=%b ready=%b wr_en=%b b=%0d, required 1/0000/0/32",
                     full, req_ready, wr_en, b_wptr);
        else n_pass++;
    endtask

    task automatic test_drain_one();
        drive_cycle(1'b0, 4'b0100, 1);
        n_checks++;
        if (full !== 1'b1 || req_ready !== 4'b0000)
            $display("FAIL drain_hold: got full=%b ready=%b, required 1/0000", full, req_ready);
        else n_pass++;
        drive_cycle(1'b0, 4'b0100, 1);
        n_checks++;
        if (full !== 1'b0 || req_ready !== 4'b0100)
            $display("FAIL drain_release: got full=%b ready=%b, required 0/0100", full, req_ready);
        else n_pass++;
        drive_cycle(1'b0, 4'b0100, 1);
        n_checks++;
        if (full !== 1'b1 || req_ready !== 4'b0000 || b_wptr !== 6'd33)
            $display("FAIL drain_refull: got full=%b ready=%b b=%0d, required 1/0000/33",
                     full, req_ready, b_wptr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int rptr;
        bit wrapped;
        wrapped = 1'b0;
        // Read pointer trails the write pointer by 30, so writes never stall.
        for (int c = 0; c < 40; c++) begin
            rptr = (m_b - 30) & 63;
            drive_cycle(1'b0, 4'b1111, rptr);
            if (cur_b < 8 && c > 20) wrapped = 1'b1;
            n_checks++;
            if (req_ready !== e_gnt || b_wptr !== 6'(cur_b) ||
                g_wptr !== tb_gray(cur_b) || full !== cur_full)
                $display("FAIL wrap_track: got ready=%b b=%0d g=%b full=%b, required ready=%b b=%0d g=%b full=%b",
                         req_ready, b_wptr, g_wptr, full, e_gnt, cur_b, tb_gray(cur_b), cur_full);
            else n_pass++;
        end
        n_checks++;
        if (!wrapped || b_wptr !== 6'(cur_b))
            $display("FAIL wrap_crossed: got b=%0d wrapped=%0d, required b=%0d wrapped=1",
                     b_wptr, wrapped, cur_b);
        else n_pass++;
        // Freeze the read pointer just past the wrap and fill to full.
        rptr = (m_b - 30) & 63;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 4'b0001, rptr);
            n_checks++;
            if (req_ready !== e_gnt || b_wptr !== 6'(cur_b) ||
                g_wptr !== tb_gray(cur_b) || full !== cur_full)
                $display("FAIL wrap_fill: got ready=%b b=%0d g=%b full=%b, required ready=%b b=%0d g=%b full=%b",
                         req_ready, b_wptr, g_wptr, full, e_gnt, cur_b, tb_gray(cur_b), cur_full);
            else n_pass++;
        end
        n_checks++;
        if (full !== 1'b1)
            $display("FAIL wrap_full: got full=%b, required 1", full);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 4'b1111, m_b);
            n_checks++;
            if (req_ready !== e_gnt)
                $display("FAIL burst_grant: got ready=%b, required %b", req_ready, e_gnt);
            else n_pass++;
        end
        drive_cycle(1'b1, 4'b1111, 0);
        n_checks++;
        if (wr_en !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL burst_reset_block: got wr_en=%b ready=%b, required 0/0000",
                     wr_en, req_ready);
        else n_pass++;
        drive_cycle(1'b0, 4'b1111, 0);
        n_checks++;
        if (b_wptr !== 6'd0 || g_wptr !== 6'd0 || full !== 1'b0 ||
            req_ready !== 4'b0001 || grant_idx !== 2'd0)
            $display("FAIL burst_after_reset: got b=%0d g=%b full=%b ready=%b idx=%0d, required 0/0/0/0001/0",
                     b_wptr, g_wptr, full, req_ready, grant_idx);
        else n_pass++;
        drive_cycle(1'b0, 4'b0000, 0);
    endtask

    initial begin
        wrst        = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        g_rptr_sync = '0;
        test_reset();
        test_round_robin();
        test_fill();
        test_drain_one();
        test_wrap();
        test_reset_mid_burst();
        @(posedge wclk);
        #1;
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drained: got %0d pending writes, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
